// File: rtl/gba_bus_pkg.sv
// Shared bus definitions for the CPU/DMA bus arbiter.
//   bus_size_t  : access size encoding carried on *_size ports (2'b11 reserved)
//   arb_state_t : arbiter state encoding, with ARB_IDLE / ARB_CPU / ARB_DMA
package gba_bus_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10
  } bus_size_t;

  typedef logic [1:0] arb_state_t;

  localparam arb_state_t ARB_IDLE = 2'd0;
  localparam arb_state_t ARB_CPU  = 2'd1;
  localparam arb_state_t ARB_DMA  = 2'd2;

endpackage

// File: rtl/bus_arbiter.sv
// Two-master (CPU, DMA) single-beat bus arbiter in front of the memory system.
// DMA has strict priority and can hold the bus across a locked burst; the CPU
// gets a one-cycle turnaround after each of its beats.
//
// Optional feature: define ARB_FAIRNESS_EN to add a consecutive-DMA-beat
// counter that forces a CPU slot after MAX_DMA_BEATS back-to-back DMA beats.
//
// Ports:
//   clock, reset             system clock, synchronous active-high reset
//   cpu_req/addr/wdata/size/write   CPU request (held until cpu_done)
//   cpu_done, cpu_pause, cpu_rdata  CPU completion, stall, read data
//   dma_req/addr/wdata/size/write   DMA request (held until dma_done)
//   dma_done, dma_rdata             DMA completion, read data
//   dma_lock                 DMA keeps ownership across beats of a burst
//   bus_addr/wdata/size/write       request to memory system (0 when idle)
//   bus_rdata, bus_pause     memory read data and wait state
//
// state    | meaning
// ---------+------------------------------------------------------------
// ARB_IDLE | no owner, bus outputs parked at 0, arbitration this cycle
// ARB_CPU  | CPU owns the bus, beat completes on bus_pause=0
// ARB_DMA  | DMA owns the bus, beat completes on bus_pause=0
module bus_arbiter
  import gba_bus_pkg::*;
#(
  parameter int unsigned MAX_DMA_BEATS = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic [1:0]  cpu_size,
  input  logic        cpu_write,
  output logic        cpu_done,
  output logic        cpu_pause,
  output logic [31:0] cpu_rdata,
  input  logic        dma_req,
  input  logic [31:0] dma_addr,
  input  logic [31:0] dma_wdata,
  input  logic [1:0]  dma_size,
  input  logic        dma_write,
  output logic        dma_done,
  output logic [31:0] dma_rdata,
  input  logic        dma_lock,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [1:0]  bus_size,
  output logic        bus_write,
  input  logic [31:0] bus_rdata,
  input  logic        bus_pause
);

  if (MAX_DMA_BEATS < 1) begin : g_param_check
    $error("bus_arbiter: MAX_DMA_BEATS must be at least 1");
  end

  arb_state_t state_q, state_d;

  // fair_cpu_idle: forced CPU slot while arbitrating from idle
  // fair_cpu_dma : forced CPU slot straight after the DMA beat completing now
  logic fair_cpu_idle;
  logic fair_cpu_dma;

`ifdef ARB_FAIRNESS_EN
  localparam int unsigned CNT_W = $clog2(MAX_DMA_BEATS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_DMA_BEATS);

  logic [CNT_W-1:0] count_q, count_d, count_inc;

  assign count_inc     = (count_q == CNT_MAX) ? count_q : count_q + CNT_W'(1);
  assign fair_cpu_idle = cpu_req && (count_q == CNT_MAX);
  assign fair_cpu_dma  = cpu_req && (count_inc == CNT_MAX);

  // A DMA->CPU handover keeps the count at max until the CPU beat clears it.
  always_comb begin
    count_d = count_q;
    if (cpu_done) begin
      count_d = '0;
    end else if (state_q == ARB_DMA && state_d == ARB_IDLE) begin
      count_d = '0;
    end else if (dma_done) begin
      count_d = count_inc;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end
`else
  assign fair_cpu_idle = 1'b0;
  assign fair_cpu_dma  = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    bus_addr  = '0;
    bus_wdata = '0;
    bus_size  = '0;
    bus_write = 1'b0;
    cpu_done  = 1'b0;
    cpu_rdata = '0;
    dma_done  = 1'b0;
    dma_rdata = '0;

    case (state_q)
      ARB_IDLE: begin
        if (fair_cpu_idle) begin
          state_d = ARB_CPU;
        end else if (dma_req) begin
          state_d = ARB_DMA;
        end else if (cpu_req) begin
          state_d = ARB_CPU;
        end
      end

      ARB_CPU: begin
        bus_addr  = cpu_addr;
        bus_wdata = cpu_wdata;
        bus_size  = cpu_size;
        bus_write = cpu_write;
        if (!cpu_req) begin
          // Owner abandoned the beat: release without a done pulse.
          state_d = ARB_IDLE;
        end else if (!bus_pause) begin
          cpu_done  = 1'b1;
          cpu_rdata = bus_rdata;
          state_d   = ARB_IDLE;
        end
      end

      ARB_DMA: begin
        bus_addr  = dma_addr;
        bus_wdata = dma_wdata;
        bus_size  = dma_size;
        bus_write = dma_write;
        if (!dma_req) begin
          state_d = ARB_IDLE;
        end else if (!bus_pause) begin
          dma_done  = 1'b1;
          dma_rdata = bus_rdata;
          if (fair_cpu_dma) begin
            state_d = ARB_CPU;
          end else if (dma_lock) begin
            state_d = ARB_DMA;
          end else begin
            state_d = ARB_IDLE;
          end
        end
      end

      default: state_d = ARB_IDLE;
    endcase

    // Reset is synchronous, but the bus must already be quiet in the reset
    // cycle itself so an abandoned beat never reports completion.
    if (reset) begin
      bus_addr  = '0;
      bus_wdata = '0;
      bus_size  = '0;
      bus_write = 1'b0;
      cpu_done  = 1'b0;
      cpu_rdata = '0;
      dma_done  = 1'b0;
      dma_rdata = '0;
    end
  end

  assign cpu_pause = cpu_req & ~cpu_done;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ARB_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

endmodule
